// File: rtl/if_pkg.sv
// Shared fetch-stage definitions: default widths, reset/NOP constants and the
// IF/ID payload record consumed by the decode stage.
package if_pkg;

    localparam int ADDR_W_DEF     = 32;
    localparam int INST_W_DEF     = 32;
    localparam int INST_BYTES_DEF = 4;

    localparam logic [ADDR_W_DEF-1:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [INST_W_DEF-1:0] NOP_INST_DEF = 32'h0000_0000;

    typedef struct packed {
        logic                  valid;
        logic [ADDR_W_DEF-1:0] pc;
        logic [INST_W_DEF-1:0] inst;
    } if_id_t;

endpackage

// File: rtl/if_stage_pipe_skid.sv
// Single-entry hold register with synchronous load and clear; clear wins.
module if_skid_buf #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    logic         valid_r;
    logic [W-1:0] data_r;
    logic         valid_nxt_s;
    logic [W-1:0] data_nxt_s;

    // Next-state selection for the held entry.
    always_comb begin
        valid_nxt_s = valid_r;
        data_nxt_s  = data_r;
        if (clear) begin
            valid_nxt_s = 1'b0;
        end else if (load) begin
            valid_nxt_s = 1'b1;
            data_nxt_s  = d;
        end else begin
            valid_nxt_s = valid_r;
        end
    end

    // Entry storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r <= 1'b0;
            data_r  <= '0;
        end else begin
            valid_r <= valid_nxt_s;
            data_r  <= data_nxt_s;
        end
    end

    assign valid = valid_r;
    assign q     = data_r;

endmodule

// File: rtl/if_stage_pipe.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle synchronous imem and
// feeds a registered IF/ID stage, parking a stalled response in a skid entry.
module if_stage_pipe
    import if_pkg::*;
#(
    parameter int                  ADDR_W     = ADDR_W_DEF,
    parameter int                  INST_W     = INST_W_DEF,
    parameter int                  INST_BYTES = INST_BYTES_DEF,
    parameter logic [ADDR_W-1:0]   RESET_PC   = ADDR_W'(RESET_PC_DEF),
    parameter logic [INST_W-1:0]   NOP_INST   = INST_W'(NOP_INST_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              id_stall,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              id_valid,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst
);

    localparam logic [ADDR_W-1:0] PC_INC     = ADDR_W'(INST_BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(INST_BYTES - 1));

    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_nxt_s;
    logic              req_valid_r;
    logic [ADDR_W-1:0] req_pc_r;
    logic              imem_en_s;

    logic              skid_valid_s;
    logic [ADDR_W-1:0] skid_pc_s;
    logic [INST_W-1:0] skid_inst_s;
    logic              skid_load_s;
    logic              skid_clear_s;

    logic              id_valid_r;
    logic [ADDR_W-1:0] id_pc_r;
    logic [INST_W-1:0] id_inst_r;
    logic              id_valid_nxt_s;
    logic [ADDR_W-1:0] id_pc_nxt_s;
    logic [INST_W-1:0] id_inst_nxt_s;

    // Issue enable and next-PC: redirect beats sequential issue beats hold.
    always_comb begin
        imem_en_s = rst & ~id_stall & ~skid_valid_s;
        pc_nxt_s  = pc_r;
        if (redirect_valid) begin
            pc_nxt_s = redirect_pc & ALIGN_MASK;
        end else if (imem_en_s) begin
            pc_nxt_s = pc_r + PC_INC;
        end else begin
            pc_nxt_s = pc_r;
        end
    end

    // PC and outstanding-request tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_r        <= RESET_PC;
            req_valid_r <= 1'b0;
            req_pc_r    <= '0;
        end else begin
            pc_r        <= pc_nxt_s;
            req_valid_r <= imem_en_s & ~redirect_valid;
            req_pc_r    <= pc_r;
        end
    end

    // Park the in-flight response when ID stalls; any accept or redirect empties it.
    always_comb begin
        skid_load_s  = id_stall & ~redirect_valid & req_valid_r;
        skid_clear_s = redirect_valid | ~id_stall;
    end

    if_skid_buf #(
        .W (ADDR_W + INST_W)
    ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .clear (skid_clear_s),
        .load  (skid_load_s),
        .d     ({req_pc_r, imem_rdata}),
        .valid (skid_valid_s),
        .q     ({skid_pc_s, skid_inst_s})
    );

    // IF/ID next value: the skid entry is older than the live response, so it goes first.
    always_comb begin
        id_valid_nxt_s = id_valid_r;
        id_pc_nxt_s    = id_pc_r;
        id_inst_nxt_s  = id_inst_r;
        if (redirect_valid) begin
            id_valid_nxt_s = 1'b0;
            id_inst_nxt_s  = NOP_INST;
        end else if (!id_stall) begin
            if (skid_valid_s) begin
                id_valid_nxt_s = 1'b1;
                id_pc_nxt_s    = skid_pc_s;
                id_inst_nxt_s  = skid_inst_s;
            end else if (req_valid_r) begin
                id_valid_nxt_s = 1'b1;
                id_pc_nxt_s    = req_pc_r;
                id_inst_nxt_s  = imem_rdata;
            end else begin
                id_valid_nxt_s = 1'b0;
                id_inst_nxt_s  = NOP_INST;
            end
        end else begin
            id_valid_nxt_s = id_valid_r;
        end
    end

    // IF/ID pipeline register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_valid_r <= 1'b0;
            id_pc_r    <= '0;
            id_inst_r  <= NOP_INST;
        end else begin
            id_valid_r <= id_valid_nxt_s;
            id_pc_r    <= id_pc_nxt_s;
            id_inst_r  <= id_inst_nxt_s;
        end
    end

    assign imem_en   = imem_en_s;
    assign imem_addr = pc_r;
    assign id_valid  = id_valid_r;
    assign id_pc     = id_pc_r;
    assign id_inst   = id_inst_r;

endmodule

// File: tb/tb_if_stage_pipe.sv
// Bench for if_stage_pipe: per-cycle vector table with an IF/ID scoreboard,
// plus hand sequences for reset and PC wrap-around.
module tb_if_stage_pipe;

    localparam logic [31:0] XOR_KEY = 32'hA5A5_0000;

    typedef struct packed {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        exp_en;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_stall;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;

    logic        imem_en_w;
    logic [31:0] imem_addr_w;
    logic [31:0] imem_rdata_w;
    logic        id_valid_w;
    logic [31:0] id_pc_w;
    logic [31:0] id_inst_w;

    int   n_cmp;
    int   n_fail;
    exp_t sb[$];
    vec_t vecs[24];

    if_stage_pipe dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_stall       (id_stall),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_inst        (id_inst)
    );

    if_stage_pipe #(
        .RESET_PC (32'hFFFF_FFF8)
    ) dut_w (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0000_0000),
        .id_stall       (1'b0),
        .imem_en        (imem_en_w),
        .imem_addr      (imem_addr_w),
        .imem_rdata     (imem_rdata_w),
        .id_valid       (id_valid_w),
        .id_pc          (id_pc_w),
        .id_inst        (id_inst_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read instruction memories: data = address ^ key, one cycle later.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= imem_addr ^ XOR_KEY;
        if (imem_en_w) imem_rdata_w <= imem_addr_w ^ XOR_KEY;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: each pushed expectation describes IF/ID after the next rising edge.
    always @(posedge clk) begin
        #2;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("id_valid", {31'd0, id_valid}, {31'd0, e.valid});
            if (e.valid) begin
                chk("id_pc", id_pc, e.pc);
                chk("id_inst", id_inst, e.pc ^ XOR_KEY);
            end else begin
                chk("id_inst_nop", id_inst, 32'h0000_0000);
            end
        end
    end

    // Drive one cycle of inputs at a falling edge, check issue side, queue the IF/ID result.
    task automatic step(input vec_t v);
        id_stall       = v.stall;
        redirect_valid = v.redir;
        redirect_pc    = v.rpc;
        sb.push_back('{valid: v.exp_valid, pc: v.exp_pc});
        #1;
        chk("imem_en", {31'd0, imem_en}, {31'd0, v.exp_en});
        chk("imem_addr", imem_addr, v.exp_addr);
        @(negedge clk);
    endtask

    // Wrap-around instance: free-running fetch from 0xFFFF_FFF8 after the first release.
    initial begin
        logic [31:0] wa[5];
        logic        wv[5];
        logic [31:0] wp[5];
        wa = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004, 32'h0000_0008};
        wv = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        wp = '{32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        @(posedge rst);
        #2;
        for (int i = 0; i < 5; i++) begin
            chk("wrap_addr", imem_addr_w, wa[i]);
            chk("wrap_valid", {31'd0, id_valid_w}, {31'd0, wv[i]});
            if (wv[i]) chk("wrap_pc", id_pc_w, wp[i]);
            @(negedge clk);
            #2;
        end
    end

    initial begin
        n_cmp          = 0;
        n_fail         = 0;
        rst            = 1'b0;
        id_stall       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0000_0000;

        //             stall redir rpc           en    addr          valid pc
        vecs[0]  = '{1'b0, 1'b0, 32'h000, 1'b1, 32'h000, 1'b0, 32'h000};
        vecs[1]  = '{1'b0, 1'b0, 32'h000, 1'b1, 32'h004, 1'b1, 32'h000};
        vecs[2]  = '{1'b0, 1'b0, 32'h000, 1'b1, 32'h008, 1'b1, 32'h004};
        vecs[3]  = '{1'b0, 1'b0, 32'h000, 1'b1, 32'h00C, 1'b1, 32'h008};
        vecs[4]  = '{1'b1, 1'b0, 32'h000, 1'b0, 32'h010, 1'b1, 32'h008};
        vecs[5]  = '{1'b1, 1'b0, 32'h000, 1'b0, 32'h010, 1'b1, 32'h008};
        vecs[6]  = '{1'b1, 1'b0, 32'h000, 1'b0, 32'h010, 1'b1, 32'h008};
        vecs[7]  = '{1'b0, 1'b0, 32'h000, 1'b0, 32'h010, 1'b1, 32'h00C};
        vecs[8]  = '{1'b0, 1'b0, 32'h000, 1'b1, 32'h010, 1'b0, 32'h000};
        vecs[9]  = '{1'b0, 1'b0, 32'h000, 1'b1, 32'h014, 1'b1, 32'h010};
        vecs[10] = '{1'b0, 1'b1, 32'h100, 1'b1, 32'h018, 1'b0, 32'h000};
        vecs[11] = '{1'b0, 1'b0, 32'h000, 1'b1, 32'h100, 1'b0, 32'h000};
        vecs[12] = '{1'b0, 1'b0, 32'h000, 1'b1, 32'h104, 1'b1, 32'h100};
        vecs[13] = '{1'b0, 1'b0, 32'h000, 1'b1, 32'h108, 1'b1, 32'h104};
        vecs[14] = '{1'b0, 1'b1, 32'h203, 1'b1, 32'h10C, 1'b0, 32'h000};
        vecs[15] = '{1'b0, 1'b0, 32'h000, 1'b1, 32'h200, 1'b0, 32'h000};
        vecs[16] = '{1'b0, 1'b0, 32'h000, 1'b1, 32'h204, 1'b1, 32'h200};
        vecs[17] = '{1'b1, 1'b0, 32'h000, 1'b0, 32'h208, 1'b1, 32'h200};
        vecs[18] = '{1'b1, 1'b1, 32'h300, 1'b0, 32'h208, 1'b0, 32'h000};
        vecs[19] = '{1'b1, 1'b0, 32'h000, 1'b0, 32'h300, 1'b0, 32'h000};
        vecs[20] = '{1'b0, 1'b0, 32'h000, 1'b1, 32'h300, 1'b0, 32'h000};
        vecs[21] = '{1'b0, 1'b0, 32'h000, 1'b1, 32'h304, 1'b1, 32'h300};
        vecs[22] = '{1'b0, 1'b0, 32'h000, 1'b1, 32'h308, 1'b1, 32'h304};
        vecs[23] = '{1'b1, 1'b0, 32'h000, 1'b0, 32'h30C, 1'b1, 32'h304};

        repeat (2) @(negedge clk);
        chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_id_pc", id_pc, 32'h0000_0000);
        chk("rst_id_inst", id_inst, 32'h0000_0000);
        chk("rst_imem_en", {31'd0, imem_en}, 32'd0);
        chk("rst_imem_addr", imem_addr, 32'h0000_0000);

        rst = 1'b1;
        for (int i = 0; i < 24; i++) step(vecs[i]);

        // Asynchronous reset while stalled with the skid full.
        rst = 1'b0;
        #1;
        chk("mid_rst_id_valid", {31'd0, id_valid}, 32'd0);
        chk("mid_rst_id_inst", id_inst, 32'h0000_0000);
        chk("mid_rst_id_pc", id_pc, 32'h0000_0000);
        chk("mid_rst_imem_en", {31'd0, imem_en}, 32'd0);
        chk("mid_rst_imem_addr", imem_addr, 32'h0000_0000);
        @(negedge clk);
        rst = 1'b1;
        step('{1'b0, 1'b0, 32'h000, 1'b1, 32'h000, 1'b0, 32'h000});
        step('{1'b0, 1'b0, 32'h000, 1'b1, 32'h004, 1'b1, 32'h000});
        step('{1'b0, 1'b0, 32'h000, 1'b1, 32'h008, 1'b1, 32'h004});
        step('{1'b0, 1'b0, 32'h000, 1'b1, 32'h00C, 1'b1, 32'h008});

        repeat (2) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
